// File: rtl/scan_sequencer_if.sv
// Transmitter-facing link of scan_sequencer: scanline descriptor, initiate strobe, done return.
interface scan_sequencer_if #(
  parameter int unsigned DW_INPUT = 8,
  parameter int unsigned ANGLE_DW = 8,
  parameter int unsigned NPTS_DW  = 13
);
  logic                tx_initiate;
  logic [DW_INPUT-1:0] tx_r_0;
  logic [ANGLE_DW-1:0] tx_angle;
  logic [NPTS_DW-1:0]  tx_num_points;
  logic                tx_done;

  modport master (output tx_initiate, tx_r_0, tx_angle, tx_num_points, input tx_done);
  modport slave  (input tx_initiate, tx_r_0, tx_angle, tx_num_points, output tx_done);
endinterface

// File: rtl/scan_sequencer.sv
// Frame-level scanline sequencer: walks a descriptor table, handshakes each line with the Transmitter.
// Define SCAN_CONTINUOUS_EN to wrap back to line 0 after the last line instead of finishing.
module scan_sequencer #(
  parameter int unsigned MAX_LINES = 16,
  parameter int unsigned DW_INPUT  = 8,
  parameter int unsigned ANGLE_DW  = 8,
  parameter int unsigned NPTS_DW   = 13,
  parameter int unsigned GAP_DW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_LINES)-1:0] cfg_addr,
  input  logic [DW_INPUT-1:0]          cfg_r_0,
  input  logic [ANGLE_DW-1:0]          cfg_angle,
  input  logic [NPTS_DW-1:0]           cfg_num_points,
  input  logic [$clog2(MAX_LINES):0]   num_lines,
  input  logic [GAP_DW-1:0]            gap_cycles,
  input  logic                         start,
  input  logic                         abort,
  scan_sequencer_if.master             tx,
  output logic [$clog2(MAX_LINES)-1:0] line_idx,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         aborted
);

  localparam int unsigned AW = $clog2(MAX_LINES);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [NPTS_DW-1:0]  num_points;
    logic [ANGLE_DW-1:0] angle;
    logic [DW_INPUT-1:0] r_0;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_WAIT_DONE, S_GAP, S_FINISH, S_DRAIN
  } state_t;

  state_t            state_q, state_nxt;
  logic [AW-1:0]     line_nxt, line_adv;
  logic [LW-1:0]     lines_q, lines_clamped;
  logic [GAP_DW-1:0] gap_cfg_q, gap_cnt_q, gap_cnt_nxt;
  logic              start_ok, last_line;
  logic              frame_fire, abort_fire, initiate_c;
  desc_t             desc_mem [MAX_LINES];
  desc_t             desc_q;

  assign start_ok      = (state_q == S_IDLE) && start;
  assign lines_clamped = (num_lines > LW'(MAX_LINES)) ? LW'(MAX_LINES) : num_lines;
  assign last_line     = ({1'b0, line_idx} == (lines_q - LW'(1)));

`ifdef SCAN_CONTINUOUS_EN
  assign line_adv = last_line ? '0 : line_idx + AW'(1);
`else
  assign line_adv = line_idx + AW'(1);
`endif

  // Descriptor table: not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      desc_mem[cfg_addr] <= {cfg_num_points, cfg_angle, cfg_r_0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      line_idx   <= '0;
      lines_q    <= '0;
      gap_cfg_q  <= '0;
      gap_cnt_q  <= '0;
      desc_q     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      line_idx   <= line_nxt;
      gap_cnt_q  <= gap_cnt_nxt;
      busy       <= (state_nxt != S_IDLE);
      frame_done <= frame_fire;
      aborted    <= abort_fire;
      if (start_ok) begin
        lines_q   <= lines_clamped;
        gap_cfg_q <= gap_cycles;
      end
      // Descriptor is captured on entry to LOAD so it is stable from LOAD through WAIT_DONE.
      if (state_nxt == S_LOAD) begin
        desc_q <= desc_mem[line_nxt];
      end
    end
  end

  // Next-state and strobe decode; abort outranks every other event in the same cycle.
  always_comb begin
    state_nxt   = state_q;
    line_nxt    = line_idx;
    gap_cnt_nxt = gap_cnt_q;
    frame_fire  = 1'b0;
    abort_fire  = 1'b0;
    initiate_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          line_nxt  = '0;
          state_nxt = (num_lines == '0) ? S_FINISH : S_LOAD;
          if (num_lines == '0) begin
            frame_fire = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          abort_fire = 1'b1;
        end else begin
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          abort_fire = 1'b1;
        end else begin
          initiate_c = 1'b1;
          state_nxt  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (abort) begin
          state_nxt  = tx.tx_done ? S_IDLE : S_DRAIN;
          abort_fire = tx.tx_done;
        end else if (tx.tx_done) begin
          gap_cnt_nxt = gap_cfg_q - GAP_DW'(1);
`ifdef SCAN_CONTINUOUS_EN
          frame_fire = last_line;
          state_nxt  = (gap_cfg_q == '0) ? S_LOAD : S_GAP;
          if (gap_cfg_q == '0) begin
            line_nxt = line_adv;
          end
`else
          if (last_line) begin
            frame_fire = 1'b1;
            state_nxt  = S_FINISH;
          end else begin
            state_nxt = (gap_cfg_q == '0) ? S_LOAD : S_GAP;
            if (gap_cfg_q == '0) begin
              line_nxt = line_adv;
            end
          end
`endif
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          abort_fire = 1'b1;
        end else if (gap_cnt_q == '0) begin
          state_nxt = S_LOAD;
          line_nxt  = line_adv;
        end else begin
          gap_cnt_nxt = gap_cnt_q - GAP_DW'(1);
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (tx.tx_done) begin
          state_nxt  = S_IDLE;
          abort_fire = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx.tx_initiate   = initiate_c;
  assign tx.tx_r_0        = desc_q.r_0;
  assign tx.tx_angle      = desc_q.angle;
  assign tx.tx_num_points = desc_q.num_points;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with a fixed-latency Transmitter model and pulse logging.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_r_0;
  logic [7:0]  cfg_angle;
  logic [12:0] cfg_num_points;
  logic [4:0]  num_lines;
  logic [15:0] gap_cycles;
  logic        start;
  logic        abort;
  logic [3:0]  line_idx;
  logic        busy;
  logic        frame_done;
  logic        aborted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d_lat = 20;
  bit pend;
  int pcnt;

  int i_cyc[$];
  int i_r0[$];
  int i_ang[$];
  int i_np[$];
  int i_line[$];
  int f_cyc[$];
  int a_cyc[$];

  scan_sequencer_if #(.DW_INPUT(8), .ANGLE_DW(8), .NPTS_DW(13)) tx_if ();

  scan_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_r_0        (cfg_r_0),
    .cfg_angle      (cfg_angle),
    .cfg_num_points (cfg_num_points),
    .num_lines      (num_lines),
    .gap_cycles     (gap_cycles),
    .start          (start),
    .abort          (abort),
    .tx             (tx_if.master),
    .line_idx       (line_idx),
    .busy           (busy),
    .frame_done     (frame_done),
    .aborted        (aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Transmitter: tx_done high exactly d_lat cycles after the initiate cycle.
  initial begin
    tx_if.tx_done = 1'b0;
    pend = 1'b0;
    pcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      tx_if.tx_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          pcnt++;
          if (pcnt == d_lat) begin
            tx_if.tx_done = 1'b1;
            pend = 1'b0;
          end
        end
        if (tx_if.tx_initiate) begin
          pend = 1'b1;
          pcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_if.tx_initiate) begin
        i_cyc.push_back(cyc);
        i_r0.push_back(int'(tx_if.tx_r_0));
        i_ang.push_back(int'(tx_if.tx_angle));
        i_np.push_back(int'(tx_if.tx_num_points));
        i_line.push_back(int'(line_idx));
      end
      if (frame_done) f_cyc.push_back(cyc);
      if (aborted)    a_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    i_cyc.delete(); i_r0.delete(); i_ang.delete(); i_np.delete(); i_line.delete();
    f_cyc.delete(); a_cyc.delete();
  endtask

  task automatic write_entry(input int a, input int r, input int g, input int n);
    tick();
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_r_0 = 8'(r); cfg_angle = 8'(g); cfg_num_points = 13'(n);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int nl, input int gap, output int sc);
    tick();
    num_lines = 5'(nl); gap_cycles = 16'(gap); start = 1'b1; sc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    int sc;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (aborted !== 1'b0)    begin errors++; $display("FAIL reset_aborted: got %b want 0", aborted); end
    checks++; if (line_idx !== 4'd0)   begin errors++; $display("FAIL reset_line_idx: got %0d want 0", line_idx); end
    checks++; if (tx_if.tx_initiate !== 1'b0) begin errors++; $display("FAIL reset_initiate: got %b want 0", tx_if.tx_initiate); end
    checks++; if ({tx_if.tx_r_0, tx_if.tx_angle, tx_if.tx_num_points} !== 29'd0)
      begin errors++; $display("FAIL reset_desc: got %h want 0", {tx_if.tx_r_0, tx_if.tx_angle, tx_if.tx_num_points}); end
    tick();
    rst = 1'b0;
    // Reset in the middle of WAIT_DONE must drop straight to idle with no pulses.
    write_entry(0, 5, 6, 7);
    d_lat = 20;
    clear_logs();
    do_start(1, 0, sc);
    while (cyc < sc + 8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (tx_if.tx_r_0 !== 8'd0) begin errors++; $display("FAIL midreset_r0: got %0d want 0", tx_if.tx_r_0); end
    repeat (30) @(negedge clk);
    checks++; if (f_cyc.size() + a_cyc.size() !== 0)
      begin errors++; $display("FAIL midreset_pulses: got %0d want 0", f_cyc.size() + a_cyc.size()); end
    checks++; if (i_cyc.size() !== 1) begin errors++; $display("FAIL midreset_initiates: got %0d want 1", i_cyc.size()); end
  endtask

  task automatic test_frame();
    int sc, at;
    bit ok;
    int er0[3] = '{70, 90, 30};
    int eang[3] = '{50, 130, 70};
    int enp[3] = '{2990, 2650, 3600};
    write_entry(0, 70, 50, 2990);
    write_entry(1, 90, 130, 2650);
    write_entry(2, 30, 70, 3600);
    d_lat = 20;
    clear_logs();
    do_start(3, 10, sc);
    wait_idle(300, ok, at);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: busy=1 want 0"); end
    checks++; if (i_cyc.size() !== 3) begin errors++; $display("FAIL frame_initiates: got %0d want 3", i_cyc.size()); end
    for (int i = 0; i < 3 && i < i_cyc.size(); i++) begin
      checks++; if (i_cyc[i] !== sc + 2 + 32 * i)
        begin errors++; $display("FAIL frame_init_cycle[%0d]: got %0d want %0d", i, i_cyc[i] - sc, 2 + 32 * i); end
      checks++; if (i_r0[i] !== er0[i])  begin errors++; $display("FAIL frame_r0[%0d]: got %0d want %0d", i, i_r0[i], er0[i]); end
      checks++; if (i_ang[i] !== eang[i]) begin errors++; $display("FAIL frame_angle[%0d]: got %0d want %0d", i, i_ang[i], eang[i]); end
      checks++; if (i_np[i] !== enp[i])  begin errors++; $display("FAIL frame_npts[%0d]: got %0d want %0d", i, i_np[i], enp[i]); end
      checks++; if (i_line[i] !== i)     begin errors++; $display("FAIL frame_line[%0d]: got %0d want %0d", i, i_line[i], i); end
    end
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", f_cyc.size()); end
    else begin
      checks++; if (f_cyc[0] !== sc + 87) begin errors++; $display("FAIL frame_done_cycle: got %0d want 87", f_cyc[0] - sc); end
    end
    checks++; if (at !== sc + 88) begin errors++; $display("FAIL frame_busy_fall: got %0d want 88", at - sc); end
  endtask

  task automatic test_zero_lines();
    int sc, at;
    bit ok;
    clear_logs();
    do_start(0, 5, sc);
    wait_idle(20, ok, at);
    repeat (5) @(negedge clk);
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", f_cyc.size()); end
    else begin
      checks++; if (f_cyc[0] !== sc + 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", f_cyc[0] - sc); end
    end
    checks++; if (i_cyc.size() !== 0) begin errors++; $display("FAIL zero_initiates: got %0d want 0", i_cyc.size()); end
    checks++; if (at !== sc + 2) begin errors++; $display("FAIL zero_busy_fall: got %0d want 2", at - sc); end
  endtask

  task automatic test_clamp();
    int sc, at;
    bit ok;
    for (int i = 0; i < 16; i++) write_entry(i, 16 + i, 3 * i, 100 * i + 7);
    d_lat = 3;
    clear_logs();
    do_start(20, 1, sc);
    wait_idle(400, ok, at);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout: busy=1 want 0"); end
    checks++; if (i_cyc.size() !== 16) begin errors++; $display("FAIL clamp_initiates: got %0d want 16", i_cyc.size()); end
    for (int i = 0; i < 16 && i < i_cyc.size(); i++) begin
      checks++; if (i_line[i] !== i) begin errors++; $display("FAIL clamp_line[%0d]: got %0d want %0d", i, i_line[i], i); end
      checks++; if (i_r0[i] !== 16 + i) begin errors++; $display("FAIL clamp_r0[%0d]: got %0d want %0d", i, i_r0[i], 16 + i); end
      checks++; if (i_cyc[i] !== sc + 2 + 6 * i)
        begin errors++; $display("FAIL clamp_cycle[%0d]: got %0d want %0d", i, i_cyc[i] - sc, 2 + 6 * i); end
    end
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL clamp_done_count: got %0d want 1", f_cyc.size()); end
  endtask

  task automatic test_abort_drain();
    int sc, at;
    bit ok;
    write_entry(0, 70, 50, 2990);
    write_entry(1, 90, 130, 2650);
    write_entry(2, 30, 70, 3600);
    d_lat = 20;
    clear_logs();
    do_start(3, 10, sc);
    // Line 1 initiates at sc+34; abort lands in its WAIT_DONE together with a table write.
    while (cyc < sc + 39) tick();
    abort = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_r_0 = 8'd11; cfg_angle = 8'd22; cfg_num_points = 13'd33;
    tick();
    abort = 1'b0; cfg_we = 1'b0;
    wait_idle(100, ok, at);
    repeat (30) @(negedge clk);
    checks++; if (at !== sc + 55) begin errors++; $display("FAIL drain_busy_fall: got %0d want 55", at - sc); end
    checks++; if (a_cyc.size() !== 1) begin errors++; $display("FAIL drain_abort_count: got %0d want 1", a_cyc.size()); end
    else begin
      checks++; if (a_cyc[0] !== sc + 55) begin errors++; $display("FAIL drain_abort_cycle: got %0d want 55", a_cyc[0] - sc); end
    end
    checks++; if (i_cyc.size() !== 2) begin errors++; $display("FAIL drain_initiates: got %0d want 2", i_cyc.size()); end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL drain_frame_done: got %0d want 0", f_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int sc, at;
    bit ok;
    d_lat = 6;
    clear_logs();
    do_start(3, 0, sc);
    // Third INIT falls at sc+18 with zero gap; abort exactly there.
    while (cyc < sc + 18) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(50, ok, at);
    repeat (20) @(negedge clk);
    checks++; if (i_cyc.size() !== 2) begin errors++; $display("FAIL b2b_initiates: got %0d want 2", i_cyc.size()); end
    else begin
      checks++; if (i_cyc[1] - i_cyc[0] !== 8) begin errors++; $display("FAIL b2b_spacing: got %0d want 8", i_cyc[1] - i_cyc[0]); end
      // Entry 1 must still hold its pre-abort contents; the write during the last frame was blocked.
      checks++; if (i_r0[1] !== 90)   begin errors++; $display("FAIL table_r0: got %0d want 90", i_r0[1]); end
      checks++; if (i_ang[1] !== 130) begin errors++; $display("FAIL table_angle: got %0d want 130", i_ang[1]); end
      checks++; if (i_np[1] !== 2650) begin errors++; $display("FAIL table_npts: got %0d want 2650", i_np[1]); end
    end
    checks++; if (a_cyc.size() !== 1) begin errors++; $display("FAIL b2b_abort_count: got %0d want 1", a_cyc.size()); end
    else begin
      checks++; if (a_cyc[0] !== sc + 19) begin errors++; $display("FAIL b2b_abort_cycle: got %0d want 19", a_cyc[0] - sc); end
    end
    checks++; if (at !== sc + 19) begin errors++; $display("FAIL b2b_busy_fall: got %0d want 19", at - sc); end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL b2b_frame_done: got %0d want 0", f_cyc.size()); end
  endtask

`ifdef SCAN_CONTINUOUS_EN
  task automatic test_continuous();
    int sc, at;
    bit ok;
    write_entry(0, 70, 50, 2990);
    write_entry(1, 90, 130, 2650);
    d_lat = 5;
    clear_logs();
    do_start(2, 3, sc);
    while (cyc < sc + 34) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(100, ok, at);
    repeat (20) @(negedge clk);
    checks++; if (i_cyc.size() !== 4) begin errors++; $display("FAIL cont_initiates: got %0d want 4", i_cyc.size()); end
    for (int i = 0; i < 4 && i < i_cyc.size(); i++) begin
      checks++; if (i_line[i] !== i % 2) begin errors++; $display("FAIL cont_line[%0d]: got %0d want %0d", i, i_line[i], i % 2); end
      checks++; if (i_cyc[i] !== sc + 2 + 10 * i)
        begin errors++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, i_cyc[i] - sc, 2 + 10 * i); end
    end
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL cont_done_count: got %0d want 1", f_cyc.size()); end
    else begin
      checks++; if (f_cyc[0] !== sc + 18) begin errors++; $display("FAIL cont_done_cycle: got %0d want 18", f_cyc[0] - sc); end
    end
    checks++; if (a_cyc.size() !== 1) begin errors++; $display("FAIL cont_abort_count: got %0d want 1", a_cyc.size()); end
    else begin
      checks++; if (a_cyc[0] !== sc + 38) begin errors++; $display("FAIL cont_abort_cycle: got %0d want 38", a_cyc[0] - sc); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_r_0 = '0; cfg_angle = '0; cfg_num_points = '0;
    num_lines = '0; gap_cycles = '0; start = 1'b0; abort = 1'b0;
    test_reset();
`ifdef SCAN_CONTINUOUS_EN
    test_zero_lines();
    test_continuous();
`else
    test_frame();
    test_zero_lines();
    test_clamp();
`endif
    test_abort_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Frame-level controller in front of the Transmitter.
- Holds a small table of scanline descriptors (r_0, angle, num_points).
- On start, walks the table: presents each descriptor, pulses initiate, waits for the Transmitter's done, inserts a programmable dead time, then moves to the next line.
- Reports frame completion and supports a clean abort that never leaves the Transmitter mid-scanline.

Parameters:
- MAX_LINES, 16, table depth (power of 2).
- DW_INPUT, 8, width of r_0 descriptor field.
- ANGLE_DW, 8, width of angle descriptor field.
- NPTS_DW, 13, width of num_points field.
- GAP_DW, 16, width of the inter-line gap counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  table write strobe; ignored while busy.
- cfg_addr  in  $clog2(MAX_LINES)  table write address.
- cfg_r_0  in  DW_INPUT  r_0 value written.
- cfg_angle  in  ANGLE_DW  angle value written.
- cfg_num_points  in  NPTS_DW  num_points value written.
- num_lines  in  $clog2(MAX_LINES)+1  lines in frame; sampled on accepted start.
- gap_cycles  in  GAP_DW  dead cycles between lines; sampled on accepted start.
- start  in  1  begin frame; accepted only in IDLE.
- abort  in  1  terminate frame.
- tx_done  in  1  Transmitter scanline-complete pulse.
- tx_initiate  out  1  one-cycle initiate to Transmitter.
- tx_r_0  out  DW_INPUT  descriptor to Transmitter.
- tx_angle  out  ANGLE_DW  descriptor to Transmitter.
- tx_num_points  out  NPTS_DW  descriptor to Transmitter.
- line_idx  out  $clog2(MAX_LINES)  index of current line.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- aborted  out  1  one-cycle pulse when an abort completes.

Behaviour:
- Reset: all outputs 0, state IDLE, line counter 0. Table contents are not reset.
- Table: synchronous write when cfg_we=1 and busy=0; write is ignored when busy=1. Read is registered into tx_* in LOAD.
- Clamping: num_lines > MAX_LINES is treated as MAX_LINES.
- States: IDLE, LOAD, INIT, WAIT_DONE, GAP, FINISH, DRAIN.
- IDLE:
  - start=1 and num_lines>0: LOAD, line_idx=0.
  - start=1 and num_lines=0: FINISH.
  - start while busy is ignored.
- LOAD: tx_* <= table[line_idx]; next state INIT.
- INIT: tx_initiate=1 for exactly this cycle; next state WAIT_DONE.
- tx_* hold stable from LOAD through end of WAIT_DONE.
- WAIT_DONE: on tx_done=1, go to FINISH if this is the last line (line_idx = num_lines-1). Otherwise go to GAP, or directly to LOAD with line_idx+1 if gap_cycles=0.
- GAP: counts exactly gap_cycles cycles, then LOAD with line_idx+1.
- FINISH: frame_done=1 for one cycle; next state IDLE.
- Latency:
  - start sampled at edge k gives tx_initiate high in cycle k+2.
  - Initiate-to-initiate spacing = D + 2 + gap_cycles, where D is the cycles from initiate to tx_done.
- tx_done seen outside WAIT_DONE and DRAIN is ignored.
- abort (priority over all other events in the same cycle):
  - In LOAD, INIT or GAP: next state IDLE and aborted pulses. tx_initiate is suppressed if abort coincides with INIT.
  - In WAIT_DONE: next state DRAIN. If tx_done is high in the same cycle, go straight to IDLE with the aborted pulse.
  - In IDLE or FINISH: ignored; frame_done still fires.
- DRAIN: waits for tx_done, then IDLE with the aborted pulse. frame_done never fires on an aborted frame.
- Reset mid-frame: immediate return to IDLE, no pulses.

Optional Feature:
- Macro: SCAN_CONTINUOUS_EN.
- Defined: at the last line, tx_done pulses frame_done, then re-enters the table at line 0 after the gap. The descriptor wrap does not reload num_lines or gap_cycles. This continues until abort, which ends through the DRAIN/IDLE rules with the aborted pulse.
- Undefined: single-frame behaviour as above. The wrap logic is absent.

Test Plan:
- Write table {(70,50,2990),(90,130,2650),(30,70,3600)}, num_lines=3, gap_cycles=10, Transmitter model returns tx_done 20 cycles after initiate, start. Required response:
  - three tx_initiate pulses carrying those exact values, spaced 32 cycles apart;
  - first initiate 2 cycles after start;
  - one frame_done pulse; busy falls the cycle after.
- num_lines=0, start -> frame_done 1 cycle later, no tx_initiate.
- num_lines=20 with MAX_LINES=16 -> exactly 16 initiates, line_idx 0..15.
- abort 5 cycles into WAIT_DONE of line 1 -> DRAIN. tx_done at 20 gives an aborted pulse, no further initiate, no frame_done. cfg_we issued during the frame leaves the table unchanged.
- gap_cycles=0 and abort in the same cycle as INIT -> back-to-back spacing D+2 before the abort, then no initiate, IDLE and aborted next cycle.
- With SCAN_CONTINUOUS_EN, 2 lines -> initiates for lines 0,1,0,1,... with frame_done after each line-1 tx_done. abort stops the sequence via DRAIN.
